// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that handles DIGIT bits per clock,
// LSB first, with a registered carry between digits. Operands are captured when
// start is accepted, and the result registers update only when an op completes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] psum;
    logic             c_r;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] dext;
    logic [WIDTH-1:0] psum_nxt;
    logic             last;

    // One digit of the add, and the partial sum with that digit entered at the MSB end
    always_comb begin
        dsum     = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
        dext     = WIDTH'(dsum[DIGIT-1:0]);
        psum_nxt = (psum >> DIGIT) | (dext << (WIDTH - DIGIT));
        last     = (cnt == CW'(NDIG - 1));
    end

    // Control FSM and datapath: accept, shift digits through, publish result on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            psum  <= '0;
            c_r   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow; the inversion happens once here
                        a_r   <= A;
                        b_r   <= B ^ {WIDTH{Sub}};
                        c_r   <= Cin ^ Sub;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1] ^ Sub;
                        psum  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r  <= a_r >> DIGIT;
                    b_r  <= b_r >> DIGIT;
                    c_r  <= dsum[DIGIT];
                    psum <= psum_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        Sum   <= psum_nxt;
                        Cout  <= dsum[DIGIT];
                        Ovf   <= (a_msb == b_msb) && (psum_nxt[WIDTH-1] != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: three serial_adder instances (W1/D1, W8/D1, W8/D4) driven
// from a vector table, hand sequences for the multi-cycle corners, and random
// ops compared against an integer-arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] A, B;
    logic       Sub, Cin;
    logic [2:0] st;

    logic [2:0] busy_v, done_v, cout_v, ovf_v;
    logic [0:0] sum1;
    logic [7:0] sum8, sum4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .Sub(Sub), .A(A[0:0]), .B(B[0:0]),
        .Cin(Cin), .busy(busy_v[0]), .done(done_v[0]), .Sum(sum1), .Cout(cout_v[0]), .Ovf(ovf_v[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .Sub(Sub), .A(A), .B(B),
        .Cin(Cin), .busy(busy_v[1]), .done(done_v[1]), .Sum(sum8), .Cout(cout_v[1]), .Ovf(ovf_v[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .Sub(Sub), .A(A), .B(B),
        .Cin(Cin), .busy(busy_v[2]), .done(done_v[2]), .Sum(sum4), .Cout(cout_v[2]), .Ovf(ovf_v[2])
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        int         w;
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    function automatic logic [7:0] sum_of(input int w);
        case (w)
            0:       return {7'b0, sum1};
            1:       return sum8;
            default: return sum4;
        endcase
    endfunction

    function automatic int ndig_of(input int w);
        case (w)
            0:       return 1;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int width_of(input int w);
        return (w == 0) ? 1 : 8;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic res_t model(input int w, input logic sub, input logic [7:0] a,
                                   input logic [7:0] b, input logic cin);
        res_t r;
        int mask = (1 << w) - 1;
        int half = 1 << (w - 1);
        int ua   = int'(a) & mask;
        int ub   = int'(b) & mask;
        int sa   = (ua >= half) ? ua - (1 << w) : ua;
        int sb   = (ub >= half) ? ub - (1 << w) : ub;
        int ur, sr;
        if (!sub) begin
            ur     = ua + ub + int'(cin);
            sr     = sa + sb + int'(cin);
            r.cout = (ur > mask);
        end else begin
            ur     = ua - ub - int'(cin);
            sr     = sa - sb - int'(cin);
            r.cout = (ur >= 0);
        end
        r.sum = 8'(ur & mask);
        r.ovf = (sr < -half) || (sr > half - 1);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, check timing, hold and result
    task automatic run_op(input int w, input logic sub, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input res_t e, input string tag);
        logic [7:0] prev_sum;
        logic       prev_c, prev_o;
        logic       hold_bad;
        int         n;
        @(negedge clk);
        A = a; B = b; Sub = sub; Cin = cin; st[w] = 1'b1;
        prev_sum = sum_of(w);
        prev_c   = cout_v[w];
        prev_o   = ovf_v[w];
        @(posedge clk); #1;
        st[w] = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Sub = 1'($urandom); Cin = 1'($urandom);
        hold_bad = 1'b0;
        n = 0;
        while (busy_v[w] && n < 20) begin
            if (sum_of(w) !== prev_sum || cout_v[w] !== prev_c || ovf_v[w] !== prev_o) hold_bad = 1'b1;
            if (done_v[w] !== 1'b0) hold_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".busy_len"}, n, ndig_of(w));
        check({tag, ".hold"}, hold_bad, 0);
        check({tag, ".done"}, done_v[w], 1);
        check({tag, ".sum"}, sum_of(w), e.sum);
        check({tag, ".cout"}, cout_v[w], e.cout);
        check({tag, ".ovf"}, ovf_v[w], e.ovf);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done_v[w], 0);
    endtask

    vec_t vecs[12];

    initial begin
        int   k, dcnt;
        res_t e;

        vecs[0]  = '{0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[2]  = '{0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[3]  = '{0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{0, 1'b0, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[8]  = '{1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[10] = '{1, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[11] = '{2, 1'b0, 8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1};

        st = 3'b000; A = 8'h00; B = 8'h00; Sub = 1'b0; Cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("rst%0d.busy", w), busy_v[w], 0);
            check($sformatf("rst%0d.done", w), done_v[w], 0);
            check($sformatf("rst%0d.sum", w), sum_of(w), 0);
            check($sformatf("rst%0d.cout", w), cout_v[w], 0);
            check($sformatf("rst%0d.ovf", w), ovf_v[w], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors with constant expectations
        for (int i = 0; i < 12; i++) begin
            e.sum  = vecs[i].es;
            e.cout = vecs[i].ec;
            e.ovf  = vecs[i].eo;
            run_op(vecs[i].w, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, e,
                   $sformatf("vec%0d", i));
        end

        // start mid-RUN ignored, then start in the DONE cycle accepted
        @(negedge clk);
        A = 8'h22; B = 8'h01; Sub = 1'b0; Cin = 1'b0; st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        k = 0;
        dcnt = 0;
        while (busy_v[1] && k < 20) begin
            if (k == 3) begin A = 8'h11; st[1] = 1'b1; end
            else st[1] = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        st[1] = 1'b0;
        check("t5.busy_len", k, 8);
        check("t5.done", done_v[1], 1);
        check("t5.sum", sum8, 8'h23);
        A = 8'h05; B = 8'h03; Sub = 1'b0; Cin = 1'b0; st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        check("t5.restart_busy", busy_v[1], 1);
        check("t5.restart_done_low", done_v[1], 0);
        k = 0;
        while (!done_v[1] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5.restart_lat", k, 8);
        check("t5.restart_sum", sum8, 8'h08);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_v[1] || busy_v[1]) dcnt++;
        end
        check("t5.no_extra_op", dcnt, 0);

        // Async reset at count=3 aborts the op
        @(negedge clk);
        A = 8'h12; B = 8'h34; Sub = 1'b0; Cin = 1'b0; st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("t6.busy", busy_v[1], 0);
        check("t6.sum", sum8, 0);
        check("t6.done", done_v[1], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_v[1] || busy_v[1]) dcnt++;
        end
        check("t6.no_done", dcnt, 0);
        run_op(1, 1'b0, 8'h12, 8'h34, 1'b0, model(8, 1'b0, 8'h12, 8'h34, 1'b0), "t6.after");

        // Random ops against the reference model
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 40; i++) begin
                logic       rs, rc;
                logic [7:0] ra, rb;
                rs = 1'($urandom);
                rc = 1'($urandom);
                ra = 8'($urandom);
                rb = 8'($urandom);
                if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b0; rc = 1'b0; end
                if (i == 1) begin ra = 8'h80; rb = 8'h7F; rs = 1'b1; rc = 1'b1; end
                run_op(w, rs, ra, rb, rc, model(width_of(w), rs, ra, rb, rc),
                       $sformatf("rnd%0d_%0d", w, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
